// File: rtl/fpu_reg_q.sv
// Queued FPU register block: DMEM-mapped operand staging, a command FIFO,
// single-issue dispatch to the FPU core and a result FIFO read back over DMEM.
module fpu_reg_q #(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int CMD_W     = 4
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             dmem_req,
    input  logic             dmem_cmd,
    input  logic [1:0]       dmem_width,
    input  logic [4:0]       dmem_addr,
    input  logic [31:0]      dmem_wdata,
    output logic             dmem_req_ack,
    output logic [31:0]      dmem_rdata,
    output logic [1:0]       dmem_resp,
    output logic             fpu_val,
    output logic [CMD_W-1:0] fpu_cmd,
    output logic [31:0]      fpu_din1,
    output logic [31:0]      fpu_din2,
    input  logic             fpu_done,
    input  logic [31:0]      fpu_result,
    output logic             irq,
    output logic             idle
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam logic [CAW:0]   CMD_FULL = (CAW+1)'(CMD_DEPTH);
    localparam logic [RAW:0]   RES_FULL = (RAW+1)'(RES_DEPTH);
    localparam logic [CAW:0]   CC_ONE   = (CAW+1)'(1);
    localparam logic [RAW:0]   RC_ONE   = (RAW+1)'(1);
    localparam logic [CAW-1:0] CP_ONE   = CAW'(1);
    localparam logic [RAW-1:0] RP_ONE   = RAW'(1);

    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic [31:0]      din1;
        logic [31:0]      din2;
    } cmd_entry_t;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t state, state_d;

    logic        acc_wr;
    logic [1:0]  acc_width;
    logic [4:0]  acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic [31:0] al_wdata;
    logic [3:0]  al_be;

    logic [31:0]      stage1, stage2;
    logic [CMD_W-1:0] last_cmd;
    logic             irq_en, cmd_ovf, res_unf;

    cmd_entry_t       cmd_mem [CMD_DEPTH];
    logic [CAW-1:0]   cmd_wptr, cmd_rptr;
    logic [CAW:0]     cmd_count;
    logic [31:0]      res_mem [RES_DEPTH];
    logic [RAW-1:0]   res_wptr, res_rptr;
    logic [RAW:0]     res_count;

    logic [2:0]  word;
    logic        mapped, wr_en, rd_en;
    logic        cmd_wr, cmd_push, ovf_set, cmd_full, cmd_empty;
    logic        res_rd, res_pop, unf_set, res_empty;
    logic        stat_clr, can_issue, issue, res_push, busy;
    logic [31:0] status, rd_word, rd_lane;

    // Lane-align write data and byte enables before capture.
    always_comb begin
        al_wdata = dmem_wdata;
        al_be    = 4'b1111;
        case (dmem_width)
            2'b00: begin
                al_wdata = {24'b0, dmem_wdata[7:0]} << {dmem_addr[1:0], 3'b000};
                al_be    = 4'b0001 << dmem_addr[1:0];
            end
            2'b01: begin
                al_wdata = {16'b0, dmem_wdata[15:0]} << {dmem_addr[1], 4'b0000};
                al_be    = 4'b0011 << {dmem_addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign word      = acc_addr[4:2];
    assign mapped    = (word < 3'd6);
    assign wr_en     = dmem_req_ack & acc_wr;
    assign rd_en     = dmem_req_ack & ~acc_wr;
    assign cmd_full  = (cmd_count == CMD_FULL);
    assign cmd_empty = (cmd_count == '0);
    assign res_empty = (res_count == '0);
    assign cmd_wr    = wr_en & (word == 3'd0) & acc_be[0];
    assign cmd_push  = cmd_wr & ~cmd_full;
    assign ovf_set   = cmd_wr & cmd_full;
    assign res_rd    = rd_en & (word == 3'd3);
    assign res_pop   = res_rd & ~res_empty;
    assign unf_set   = res_rd & res_empty;
    assign stat_clr  = wr_en & (word == 3'd4) & acc_be[3];
    // A result slot must be free before issue so the result FIFO never overflows.
    assign can_issue = ~cmd_empty & (res_count < RES_FULL);
    assign idle      = cmd_empty & (state == S_IDLE);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (can_issue) state_d = S_BUSY;
            S_BUSY:  if (fpu_done)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue    = 1'b0;
        res_push = 1'b0;
        busy     = 1'b0;
        case (state)
            S_IDLE:  issue = can_issue;
            S_BUSY:  begin busy = 1'b1; res_push = fpu_done; end
            default: ;
        endcase
    end

    assign status = {6'b0, res_unf, cmd_ovf, 6'b0, res_empty, cmd_full,
                     8'(res_count), 8'(cmd_count)};

    always_comb begin
        case (word)
            3'd0:    rd_word = {busy, {(31-CMD_W){1'b0}}, last_cmd};
            3'd1:    rd_word = stage1;
            3'd2:    rd_word = stage2;
            3'd3:    rd_word = res_empty ? 32'b0 : res_mem[res_rptr];
            3'd4:    rd_word = status;
            3'd5:    rd_word = {31'b0, irq_en};
            default: rd_word = 32'b0;
        endcase
        case (acc_width)
            2'b00:   rd_lane = {24'b0, rd_word[{acc_addr[1:0], 3'b000} +: 8]};
            2'b01:   rd_lane = {16'b0, rd_word[{acc_addr[1], 4'b0000} +: 16]};
            default: rd_lane = rd_word;
        endcase
    end

    // Bus front end: ack toggles on a held request, access runs while ack=1.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req_ack <= 1'b0;
            dmem_resp    <= 2'b00;
            dmem_rdata   <= '0;
            acc_wr       <= 1'b0;
            acc_width    <= '0;
            acc_addr     <= '0;
            acc_wdata    <= '0;
            acc_be       <= '0;
        end else begin
            dmem_req_ack <= dmem_req & ~dmem_req_ack;
            if (dmem_req & ~dmem_req_ack) begin
                acc_wr    <= dmem_cmd;
                acc_width <= dmem_width;
                acc_addr  <= dmem_addr;
                acc_wdata <= al_wdata;
                acc_be    <= al_be;
            end
            dmem_resp  <= dmem_req_ack ? (mapped ? 2'b01 : 2'b10) : 2'b00;
            dmem_rdata <= (rd_en & mapped) ? rd_lane : 32'b0;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            stage1   <= '0;
            stage2   <= '0;
            last_cmd <= '0;
            irq_en   <= 1'b0;
            cmd_ovf  <= 1'b0;
            res_unf  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_en && word == 3'd1 && acc_be[i]) stage1[8*i +: 8] <= acc_wdata[8*i +: 8];
                if (wr_en && word == 3'd2 && acc_be[i]) stage2[8*i +: 8] <= acc_wdata[8*i +: 8];
            end
            if (wr_en && word == 3'd5 && acc_be[0]) irq_en <= acc_wdata[0];
            if (cmd_push) last_cmd <= acc_wdata[CMD_W-1:0];
            // Set beats clear when both land on the same edge.
            cmd_ovf <= ovf_set | (cmd_ovf & ~(stat_clr & acc_wdata[24]));
            res_unf <= unf_set | (res_unf & ~(stat_clr & acc_wdata[25]));
            irq     <= irq_en & ~res_empty;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CMD_DEPTH; i++) cmd_mem[i] <= '0;
            cmd_wptr  <= '0;
            cmd_rptr  <= '0;
            cmd_count <= '0;
            fpu_val   <= 1'b0;
            fpu_cmd   <= '0;
            fpu_din1  <= '0;
            fpu_din2  <= '0;
        end else begin
            if (cmd_push) begin
                cmd_mem[cmd_wptr] <= '{cmd: acc_wdata[CMD_W-1:0], din1: stage1, din2: stage2};
                cmd_wptr          <= cmd_wptr + CP_ONE;
            end
            if (issue) begin
                cmd_rptr <= cmd_rptr + CP_ONE;
                {fpu_cmd, fpu_din1, fpu_din2} <= cmd_mem[cmd_rptr];
            end
            fpu_val <= issue;
            case ({cmd_push, issue})
                2'b10:   cmd_count <= cmd_count + CC_ONE;
                2'b01:   cmd_count <= cmd_count - CC_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RES_DEPTH; i++) res_mem[i] <= '0;
            res_wptr  <= '0;
            res_rptr  <= '0;
            res_count <= '0;
        end else begin
            if (res_push) begin
                res_mem[res_wptr] <= fpu_result;
                res_wptr          <= res_wptr + RP_ONE;
            end
            if (res_pop) res_rptr <= res_rptr + RP_ONE;
            case ({res_push, res_pop})
                2'b10:   res_count <= res_count + RC_ONE;
                2'b01:   res_count <= res_count - RC_ONE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_reg_q.sv
// Directed bench for fpu_reg_q: bus-driven stimulus, queued expected FPU
// operands and results, FPU core behaviour modelled in the stimulus sequence.
module tb_fpu_reg_q;
    logic        mclk = 1'b0, rst_n = 1'b0;
    logic        dmem_req = 1'b0, dmem_cmd = 1'b0;
    logic [1:0]  dmem_width = 2'b10;
    logic [4:0]  dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic        dmem_req_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;
    logic        fpu_val;
    logic [3:0]  fpu_cmd;
    logic [31:0] fpu_din1, fpu_din2;
    logic        fpu_done = 1'b0;
    logic [31:0] fpu_result = '0;
    logic        irq, idle;

    int checks = 0, failures = 0, val_count = 0, v0;
    logic [31:0] exp_res[$];
    logic [67:0] exp_op[$];
    logic [67:0] mon_op;
    logic [31:0] m_din1, m_din2, e, r;
    logic [1:0]  s;

    fpu_reg_q #(.CMD_DEPTH(4), .RES_DEPTH(4), .CMD_W(4)) dut (
        .mclk(mclk), .rst_n(rst_n), .dmem_req(dmem_req), .dmem_cmd(dmem_cmd),
        .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .fpu_val(fpu_val), .fpu_cmd(fpu_cmd), .fpu_din1(fpu_din1), .fpu_din2(fpu_din2),
        .fpu_done(fpu_done), .fpu_result(fpu_result), .irq(irq), .idle(idle)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every issue pulse is matched against the next expected operand set.
    always @(negedge mclk) begin
        if (rst_n && fpu_val) begin
            val_count++;
            if (exp_op.size() == 0) chk("fpu_val_unexpected", {31'b0, fpu_val}, 32'd0);
            else begin
                mon_op = exp_op.pop_front();
                chk("fpu_cmd", 32'(fpu_cmd), 32'(mon_op[67:64]));
                chk("fpu_din1", fpu_din1, mon_op[63:32]);
                chk("fpu_din2", fpu_din2, mon_op[31:0]);
            end
        end
    end

    task automatic bus(input logic wr, input logic [1:0] w, input logic [4:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] rs);
        int n;
        @(negedge mclk);
        dmem_req = 1'b1; dmem_cmd = wr; dmem_width = w; dmem_addr = a; dmem_wdata = wd;
        n = 0;
        do begin @(posedge mclk); #1; n++; end while (!dmem_req_ack && n < 8);
        chk("ack", {31'b0, dmem_req_ack}, 32'd1);
        dmem_req = 1'b0;
        @(posedge mclk); #1;
        rd = dmem_rdata; rs = dmem_resp;
    endtask

    task automatic wr(input logic [1:0] w, input logic [4:0] a, input logic [31:0] d);
        logic [31:0] rr; logic [1:0] ss;
        bus(1'b1, w, a, d, rr, ss);
        chk("wr_resp", 32'(ss), 32'd1);
    endtask

    task automatic rd(input string tag, input logic [1:0] w, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] rr; logic [1:0] ss;
        bus(1'b0, w, a, 32'd0, rr, ss);
        chk(tag, rr, exp);
        chk({tag, "_resp"}, 32'(ss), 32'd1);
    endtask

    task automatic rd_res(input string tag);
        logic [31:0] ex;
        ex = (exp_res.size() != 0) ? exp_res.pop_front() : 32'd0;
        rd(tag, 2'b10, 5'h0C, ex);
    endtask

    task automatic push_cmd(input logic [3:0] c, input bit accept);
        if (accept) exp_op.push_back({c, m_din1, m_din2});
        wr(2'b10, 5'h00, {28'b0, c});
    endtask

    task automatic respond(input logic [31:0] res);
        @(negedge mclk);
        fpu_done = 1'b1; fpu_result = res;
        exp_res.push_back(res);
        @(negedge mclk);
        fpu_done = 1'b0;
    endtask

    task automatic wait_val(input string tag);
        int n;
        n = 0;
        @(negedge mclk);
        while (!fpu_val && n < 20) begin @(negedge mclk); n++; end
        chk(tag, {31'b0, fpu_val}, 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge mclk);
        chk("rst_ack", {31'b0, dmem_req_ack}, 32'd0);
        chk("rst_resp", 32'(dmem_resp), 32'd0);
        chk("rst_rdata", dmem_rdata, 32'd0);
        chk("rst_fpu_val", {31'b0, fpu_val}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_idle", {31'b0, idle}, 32'd1);
        rst_n = 1'b1;

        // Single operation round trip
        m_din1 = 32'h3F800000; m_din2 = 32'h40000000;
        wr(2'b10, 5'h04, m_din1);
        wr(2'b10, 5'h08, m_din2);
        push_cmd(4'h1, 1'b1);
        wait_val("t1_val");
        @(negedge mclk);
        chk("t1_val_pulse", {31'b0, fpu_val}, 32'd0);
        chk("t1_cmd_held", 32'(fpu_cmd), 32'd1);
        chk("t1_din1_held", fpu_din1, 32'h3F800000);
        chk("t1_din2_held", fpu_din2, 32'h40000000);
        rd("t1_cmd_rd", 2'b10, 5'h00, 32'h80000001);
        respond(32'h40400000);
        rd("t1_status1", 2'b10, 5'h10, 32'h00000100);
        rd_res("t1_result");
        rd("t1_status0", 2'b10, 5'h10, 32'h00020000);

        // Command FIFO overflow; result FIFO back-pressure
        v0 = val_count;
        for (int i = 0; i < 6; i++) push_cmd(4'(2 + i), i < 5);
        rd("t2_status_ovf", 2'b10, 5'h10, 32'h01030004);
        chk("t2_idle", {31'b0, idle}, 32'd0);
        wr(2'b10, 5'h10, 32'h01000000);
        rd("t2_status_clr", 2'b10, 5'h10, 32'h00030004);
        respond(32'hA0000000);
        for (int i = 1; i < 4; i++) begin
            wait_val("t3_val");
            respond(32'hA0000000 + 32'(i));
        end
        repeat (5) @(negedge mclk);
        chk("t3_val_pulses", 32'(val_count - v0), 32'd4);
        rd("t3_status_full", 2'b10, 5'h10, 32'h00000401);
        rd_res("t3_res0");
        wait_val("t3_val5");
        respond(32'hA0000004);
        for (int i = 1; i < 5; i++) rd_res("t3_res");
        rd("t3_status_end", 2'b10, 5'h10, 32'h00020000);

        // Empty result read, unmapped access, byte/half lanes
        rd_res("t4_empty_res");
        rd("t4_status_unf", 2'b10, 5'h10, 32'h02020000);
        bus(1'b0, 2'b10, 5'h18, 32'd0, r, s);
        chk("t4_unmapped_rdata", r, 32'd0);
        chk("t4_unmapped_resp", 32'(s), 32'd2);
        wr(2'b10, 5'h04, 32'h11223344);
        rd("t4_byte_rd", 2'b00, 5'h05, 32'h00000033);
        rd("t4_half_rd", 2'b01, 5'h06, 32'h00001122);
        wr(2'b00, 5'h07, 32'h00000099);
        rd("t4_byte_wr", 2'b10, 5'h04, 32'h99223344);
        m_din1 = 32'h99223344;
        wr(2'b00, 5'h13, 32'h00000002);
        rd("t4_status_clr", 2'b10, 5'h10, 32'h00020000);
        chk("t4_idle", {31'b0, idle}, 32'd1);

        // Interrupt timing and simultaneous done + pop
        wr(2'b10, 5'h14, 32'd1);
        push_cmd(4'h8, 1'b1);
        wait_val("t5_val1");
        respond(32'hB0000001);
        chk("t5_irq_low", {31'b0, irq}, 32'd0);
        @(negedge mclk);
        chk("t5_irq_rise", {31'b0, irq}, 32'd1);
        push_cmd(4'hC, 1'b1);
        wait_val("t5_val2");
        @(negedge mclk);
        dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'b10; dmem_addr = 5'h0C;
        @(posedge mclk); #1;
        chk("t5_sim_ack", {31'b0, dmem_req_ack}, 32'd1);
        dmem_req = 1'b0;
        @(negedge mclk);
        fpu_done = 1'b1; fpu_result = 32'hB0000002;
        e = exp_res.pop_front();
        exp_res.push_back(32'hB0000002);
        @(posedge mclk); #1;
        fpu_done = 1'b0;
        chk("t5_sim_rdata", dmem_rdata, e);
        chk("t5_sim_resp", 32'(dmem_resp), 32'd1);
        rd("t5_sim_status", 2'b10, 5'h10, 32'h00000100);
        rd_res("t5_res2");
        chk("t5_irq_hold", {31'b0, irq}, 32'd1);
        @(posedge mclk); #1;
        chk("t5_irq_fall", {31'b0, irq}, 32'd0);

        // Reset while busy with queued commands
        push_cmd(4'h9, 1'b1);
        push_cmd(4'hA, 1'b1);
        push_cmd(4'hB, 1'b1);
        rd("t6_status_busy", 2'b10, 5'h10, 32'h00020002);
        rd("t6_cmd_busy", 2'b10, 5'h00, 32'h8000000B);
        @(negedge mclk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_val", {31'b0, fpu_val}, 32'd0);
        chk("t6_rst_idle", {31'b0, idle}, 32'd1);
        chk("t6_rst_irq", {31'b0, irq}, 32'd0);
        exp_op.delete();
        repeat (2) @(negedge mclk);
        rst_n = 1'b1;
        rd("t6_status_rst", 2'b10, 5'h10, 32'h00020000);
        rd("t6_irq_en_rst", 2'b10, 5'h14, 32'd0);
        v0 = val_count;
        @(negedge mclk); fpu_done = 1'b1; fpu_result = 32'hDEADBEEF;
        @(negedge mclk); fpu_done = 1'b0;
        repeat (3) @(negedge mclk);
        rd("t6_stray_done", 2'b10, 5'h10, 32'h00020000);
        chk("t6_stray_idle", {31'b0, idle}, 32'd1);
        chk("t6_stray_val", 32'(val_count - v0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
